pulse_train_sequencer: RTL

PULSE_TRAIN_SEQUENCER -- requirements
Module: pulse_train_sequencer

---
 rtl/pulse_train_sequencer_if.sv | 34 +++
 rtl/pulse_train_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/pulse_train_sequencer_if.sv
// Bundle between a pulse train sequencer and the controller / duration source
// that feeds it.
//   start, abort : train control from the controller
//   num_seg      : segments per train (0 means 16)
//   dur_in       : duration presented by the data source, advanced by next
//   next         : one-cycle strobe, dur_in consumed this cycle
//   pulse_out    : generated pulse train
//   busy, done   : train in progress / one-cycle completion strobe
//   seg_idx      : index of the segment currently running
//   err          : sticky zero-duration flag
interface pulse_train_sequencer_if #(
    parameter int unsigned DUR_W = 16
);
    logic             start;
    logic             abort;
    logic [4:0]       num_seg;
    logic [DUR_W-1:0] dur_in;
    logic             next;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [4:0]       seg_idx;
    logic             err;

    modport master (
        output start, abort, num_seg, dur_in,
        input  next, pulse_out, busy, done, seg_idx, err
    );

    modport slave (
        input  start, abort, num_seg, dur_in,
        output next, pulse_out, busy, done, seg_idx, err
    );
endinterface

// File: rtl/pulse_train_sequencer.sv
// Pulse train sequencer: plays N back-to-back segments whose lengths come from
// an external duration source. Even-index segments drive pulse_out high, odd
// ones low. A train ends with a one-cycle DONE state.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : slave side of pulse_train_sequencer_if (control, data source, status)
module pulse_train_sequencer #(
    parameter int unsigned DUR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pulse_train_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [3:0]       seg_q, seg_d;
    logic [3:0]       last_q, last_d;
    logic             err_q, err_d;
    logic             load;
    logic             dur_zero;
    logic [DUR_W-1:0] load_val;

    localparam logic [DUR_W-1:0] CntOne = {{(DUR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        last_d   = last_q;
        err_d    = err_q;
        load     = 1'b0;
        dur_zero = (bus.dur_in == '0);
        // A zero duration would never reach the counter==1 end condition.
        load_val = dur_zero ? CntOne : bus.dur_in;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = load_val;
                    seg_d   = 4'd0;
                    // num_seg of 0 or 16 both wrap to a last index of 15.
                    last_d  = bus.num_seg[3:0] - 4'd1;
                    err_d   = dur_zero;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CntOne) begin
                    if (seg_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        load  = 1'b1;
                        cnt_d = load_val;
                        seg_d = seg_q + 4'd1;
                        err_d = err_q | dur_zero;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            seg_q   <= 4'd0;
            last_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.next      = load;
    assign bus.pulse_out = (state_q == StRun) & ~seg_q[0];
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.seg_idx   = {1'b0, seg_q};
    assign bus.err       = err_q;

endmodule
